// File: rtl/stream_pkg.sv
// stream_pkg: shared state encoding, default widths and keep-mask helper for the stream byte blocks
package stream_pkg;
  localparam int DATA_WD_DEF = 32;
  localparam int MAX_BYTES = 64;
  typedef enum logic [1:0] {WAIT_HDR = 2'd0, STREAM = 2'd1, EXTRA = 2'd2} state_t;
  function automatic logic [MAX_BYTES-1:0] cnt_to_keep(input int unsigned cnt);
    return cnt >= MAX_BYTES ? '1 : (MAX_BYTES'(1) << cnt) - MAX_BYTES'(1);
  endfunction
endpackage

// File: rtl/stream_byte_shift.sv
// stream_byte_shift: right-shifts a double-width {hi,lo} data/keep pair by a byte count, returning the low word
module stream_byte_shift import stream_pkg::*; #(
  parameter int DATA_WD = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD >> 3,
  parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic [DATA_WD-1:0]      hi,
  input  logic [DATA_WD-1:0]      lo,
  input  logic [DATA_BYTE_WD-1:0] hi_keep,
  input  logic [DATA_BYTE_WD-1:0] lo_keep,
  input  logic [BYTE_CNT_WD-1:0]  cnt,
  output logic [DATA_WD-1:0]      data,
  output logic [DATA_BYTE_WD-1:0] keep
);
  logic [2*DATA_WD-1:0] d_sh;
  logic [2*DATA_BYTE_WD-1:0] k_sh;
  // shift data by 8*cnt bits and keep by cnt bits, then take the low half
  always_comb begin
    d_sh = {hi, lo} >> {cnt, 3'b000};
    k_sh = {hi_keep, lo_keep} >> cnt;
    data = d_sh[DATA_WD-1:0];
    keep = k_sh[DATA_BYTE_WD-1:0];
  end
endmodule

// File: rtl/stream_insert.sv
// stream_insert: prepends a 0..DATA_BYTE_WD byte header to each AXI-Stream packet, keeping output densely packed
module stream_insert import stream_pkg::*; #(
  parameter int DATA_WD = DATA_WD_DEF,
  parameter int DATA_BYTE_WD = DATA_WD >> 3,
  parameter int BYTE_CNT_WD = $clog2(DATA_BYTE_WD) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    valid_in,
  input  logic [DATA_WD-1:0]      data_in,
  input  logic [DATA_BYTE_WD-1:0] keep_in,
  input  logic                    last_in,
  output logic                    ready_in,
  output logic                    valid_out,
  output logic [DATA_WD-1:0]      data_out,
  output logic [DATA_BYTE_WD-1:0] keep_out,
  output logic                    last_out,
  input  logic                    ready_out,
  input  logic                    valid_insert,
  input  logic [DATA_WD-1:0]      data_insert,
  input  logic [DATA_BYTE_WD-1:0] keep_insert,
  input  logic [BYTE_CNT_WD-1:0]  byte_insert_cnt,
  output logic                    ready_insert
);
  state_t state;
  logic [DATA_WD-1:0] res_data;
  logic [DATA_BYTE_WD-1:0] res_keep;
  logic [BYTE_CNT_WD-1:0] h_r;
  logic [DATA_BYTE_WD-1:0] keep_sh;
  logic [DATA_BYTE_WD-1:0] keep_spill;
  logic need_extra;
  logic in_stream;
  logic in_extra;
  assign in_stream = state == STREAM;
  assign in_extra = state == EXTRA;
  // in EXTRA only the residual is left, so the lower word is flushed as zero
  stream_byte_shift #(
    .DATA_WD(DATA_WD),
    .DATA_BYTE_WD(DATA_BYTE_WD),
    .BYTE_CNT_WD(BYTE_CNT_WD)
  ) u_shift (
    .hi(res_data),
    .lo(in_extra ? '0 : data_in),
    .hi_keep(res_keep),
    .lo_keep(in_extra ? '0 : keep_in),
    .cnt(h_r),
    .data(data_out),
    .keep(keep_sh)
  );
  // handshake and beat-qualifier decode; bytes pushed past the low word force an extra flush beat
  always_comb begin
    keep_spill = keep_in << (BYTE_CNT_WD'(DATA_BYTE_WD) - h_r);
    need_extra = |keep_spill;
    valid_out = in_stream ? valid_in : in_extra;
    ready_in = in_stream & ready_out;
    ready_insert = state == WAIT_HDR;
    last_out = in_stream ? last_in & ~need_extra : in_extra;
    keep_out = valid_out ? keep_sh : '0;
  end
  // packet sequencing and residual capture; registers only move on a handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= WAIT_HDR;
      res_data <= '0;
      res_keep <= '0;
      h_r <= '0;
    end else begin
      case (state)
        WAIT_HDR: if (valid_insert) begin
          res_data <= data_insert;
          res_keep <= keep_insert;
          h_r <= byte_insert_cnt;
          state <= STREAM;
        end
        STREAM: if (valid_in && ready_out) begin
          res_data <= data_in;
          res_keep <= keep_in;
          if (last_in) state <= need_extra ? EXTRA : WAIT_HDR;
        end
        EXTRA: if (ready_out) state <= WAIT_HDR;
        default: state <= WAIT_HDR;
      endcase
    end
  end
endmodule

// File: tb/tb_stream_insert.sv
// tb_stream_insert: randomized and directed checks of stream_insert against a byte-queue reference model
module tb_stream_insert;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic valid_in = 1'b0;
  logic [31:0] data_in = '0;
  logic [3:0] keep_in = '0;
  logic last_in = 1'b0;
  logic ready_in;
  logic valid_out;
  logic [31:0] data_out;
  logic [3:0] keep_out;
  logic last_out;
  logic ready_out = 1'b0;
  logic valid_insert = 1'b0;
  logic [31:0] data_insert = '0;
  logic [3:0] keep_insert = '0;
  logic [2:0] byte_insert_cnt = '0;
  logic ready_insert;
  int tests = 0;
  int fails = 0;
  logic [7:0] pay[$];

  stream_insert dut (
    .clk(clk), .rst_n(rst_n),
    .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
    .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
    .valid_insert(valid_insert), .data_insert(data_insert), .keep_insert(keep_insert),
    .byte_insert_cnt(byte_insert_cnt), .ready_insert(ready_insert)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && valid_insert)
      assert (byte_insert_cnt <= 3'd4 && {60'd0, keep_insert} == stream_pkg::cnt_to_keep(int'(byte_insert_cnt)));
    if (rst_n && valid_in)
      assert (last_in ? (keep_in inside {4'b1000, 4'b1100, 4'b1110, 4'b1111}) : keep_in == 4'hF);
  end

  task automatic run_packet(input int h, input logic [31:0] hdr, input bit rnd);
    logic [7:0] bq[$];
    logic [31:0] ed[$];
    logic [3:0] ek[$];
    logic el[$];
    logic [31:0] d, km, hold_d;
    logic [3:0] k, hold_k;
    logic hold_l, exp_vo;
    int pi, nb, oi, cyc;
    bit hdr_done, vin_hold, stalled;
    bq = {};
    for (int i = h - 1; i >= 0; i--) bq.push_back(hdr[8*i+:8]);
    foreach (pay[i]) bq.push_back(pay[i]);
    for (int b = 0; b < bq.size(); b += 4) begin
      d = '0;
      k = '0;
      for (int j = 0; j < 4; j++) if (b + j < bq.size()) begin
        d[31-8*j-:8] = bq[b+j];
        k[3-j] = 1'b1;
      end
      ed.push_back(d);
      ek.push_back(k);
      el.push_back(b + 4 >= bq.size());
    end
    nb = (pay.size() + 3) / 4;
    pi = 0; oi = 0; cyc = 0;
    hdr_done = 0; vin_hold = 0; stalled = 0;
    hold_d = '0; hold_k = '0; hold_l = 1'b0;
    while (oi < ed.size() && cyc < 2000) begin
      @(negedge clk);
      valid_insert = !hdr_done && (!rnd || $urandom_range(0, 1) == 1);
      data_insert = hdr;
      keep_insert = 4'((1 << h) - 1);
      byte_insert_cnt = 3'(h);
      if (!vin_hold) begin
        valid_in = pi < nb && (!rnd || $urandom_range(0, 3) != 0);
        d = $urandom;
        k = '0;
        for (int j = 0; j < 4; j++) if (4 * pi + j < pay.size()) begin
          d[31-8*j-:8] = pay[4*pi+j];
          k[3-j] = 1'b1;
        end
        data_in = d;
        keep_in = k;
        last_in = pi == nb - 1;
      end
      ready_out = !rnd || $urandom_range(0, 3) != 0;
      #1;
      exp_vo = hdr_done && (pi < nb ? valid_in : 1'b1);
      tests += 3;
      if (ready_insert !== !hdr_done) begin
        fails++;
        $display("FAIL ready_insert: got %b want %b (h=%0d beat %0d)", ready_insert, !hdr_done, h, oi);
      end
      if (ready_in !== (hdr_done && pi < nb && ready_out)) begin
        fails++;
        $display("FAIL ready_in: got %b want %b (h=%0d beat %0d)", ready_in, hdr_done && pi < nb && ready_out, h, oi);
      end
      if (valid_out !== exp_vo) begin
        fails++;
        $display("FAIL valid_out: got %b want %b (h=%0d beat %0d)", valid_out, exp_vo, h, oi);
      end
      if (valid_out && exp_vo) begin
        for (int j = 0; j < 4; j++) km[8*j+:8] = {8{ek[oi][j]}};
        tests += 3;
        if ((data_out & km) !== (ed[oi] & km)) begin
          fails++;
          $display("FAIL data_out: got %h want %h mask %h (h=%0d beat %0d)", data_out, ed[oi], km, h, oi);
        end
        if (keep_out !== ek[oi]) begin
          fails++;
          $display("FAIL keep_out: got %b want %b (h=%0d beat %0d)", keep_out, ek[oi], h, oi);
        end
        if (last_out !== el[oi]) begin
          fails++;
          $display("FAIL last_out: got %b want %b (h=%0d beat %0d)", last_out, el[oi], h, oi);
        end
        if (stalled) begin
          tests++;
          if (data_out !== hold_d || keep_out !== hold_k || last_out !== hold_l) begin
            fails++;
            $display("FAIL stall_stable: got %h/%b/%b want %h/%b/%b", data_out, keep_out, last_out, hold_d, hold_k, hold_l);
          end
        end
      end
      stalled = valid_out && !ready_out;
      hold_d = data_out;
      hold_k = keep_out;
      hold_l = last_out;
      if (valid_in && ready_in) begin
        pi++;
        vin_hold = 0;
      end else vin_hold = valid_in;
      if (valid_out && ready_out) oi++;
      if (valid_insert && ready_insert) hdr_done = 1;
      cyc++;
    end
    @(negedge clk);
    valid_in = 1'b0;
    valid_insert = 1'b0;
    #1;
    tests += 2;
    if (cyc >= 2000) begin
      fails++;
      $display("FAIL timeout: got %0d beats want %0d (h=%0d)", oi, ed.size(), h);
    end
    if (ready_insert !== 1'b1) begin
      fails++;
      $display("FAIL ready_insert_idle: got %b want 1", ready_insert);
    end
  endtask

  task automatic test_reset();
    #1;
    tests += 5;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL rst_valid_out: got %b want 0", valid_out); end
    if (ready_in !== 1'b0) begin fails++; $display("FAIL rst_ready_in: got %b want 0", ready_in); end
    if (last_out !== 1'b0) begin fails++; $display("FAIL rst_last_out: got %b want 0", last_out); end
    if (keep_out !== 4'b0) begin fails++; $display("FAIL rst_keep_out: got %b want 0000", keep_out); end
    if (ready_insert !== 1'b1) begin fails++; $display("FAIL rst_ready_insert: got %b want 1", ready_insert); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_h2_extra();
    pay = {8'h11, 8'h22, 8'h33, 8'h44};
    run_packet(2, 32'h0000AABB, 0);
  endtask

  task automatic test_h2_fit();
    pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_packet(2, 32'h0000AABB, 0);
  endtask

  task automatic test_h0();
    pay = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B};
    run_packet(0, 32'h12345678, 0);
  endtask

  task automatic test_h4();
    pay = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    run_packet(4, 32'hDEADBEEF, 0);
  endtask

  task automatic test_random();
    int n;
    for (int p = 0; p < 200; p++) begin
      n = $urandom_range(1, 12);
      pay = {};
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      run_packet($urandom_range(0, 4), $urandom, 1);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid_insert = 1'b1;
    data_insert = 32'h0000CCDD;
    keep_insert = 4'b0011;
    byte_insert_cnt = 3'd2;
    @(negedge clk);
    valid_insert = 1'b0;
    valid_in = 1'b1;
    data_in = 32'h11223344;
    keep_in = 4'hF;
    last_in = 1'b0;
    ready_out = 1'b1;
    #1;
    tests++;
    if (valid_out !== 1'b1) begin fails++; $display("FAIL mid_valid_out: got %b want 1", valid_out); end
    #2;
    rst_n = 1'b0;
    #1;
    tests += 3;
    if (valid_out !== 1'b0) begin fails++; $display("FAIL async_valid_out: got %b want 0", valid_out); end
    if (ready_in !== 1'b0) begin fails++; $display("FAIL async_ready_in: got %b want 0", ready_in); end
    if (last_out !== 1'b0) begin fails++; $display("FAIL async_last_out: got %b want 0", last_out); end
    @(negedge clk);
    valid_in = 1'b0;
    rst_n = 1'b1;
    #1;
    tests++;
    if (ready_insert !== 1'b1) begin fails++; $display("FAIL post_rst_ready_insert: got %b want 1", ready_insert); end
    pay = {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    run_packet(3, 32'h00C0FFEE, 0);
  endtask

  initial begin
    test_reset();
    test_h2_extra();
    test_h2_fit();
    test_h0();
    test_h4();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_insert.md
Name: stream_insert

Overview:
- Prepends a variable-length header (0..DATA_BYTE_WD bytes) to the front of each AXI-Stream packet. This is the inverse of the existing stream byte-remove block.
- Payload bytes are re-packed so the output stream stays densely packed and MSB-first.
- Sits on the transmit side, ahead of framing logic.
- Zero-cycle data path in steady state. A one-beat residual register carries the bytes displaced by the header.

Parameters:
- DATA_WD, 32, stream data width in bits (multiple of 8).
- DATA_BYTE_WD, DATA_WD>>3, bytes per beat.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD)+1, width of the header byte count (must hold 0..DATA_BYTE_WD).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- valid_in  in  1  payload beat valid.
- data_in  in  DATA_WD  payload data; first byte in MSBs.
- keep_in  in  DATA_BYTE_WD  payload byte enables. All ones except on the last beat, which is MSB-aligned (e.g. 4'b1100).
- last_in  in  1  last payload beat.
- ready_in  out  1  payload ready.
- valid_out  out  1  output beat valid.
- data_out  out  DATA_WD  output data.
- keep_out  out  DATA_BYTE_WD  output byte enables.
- last_out  out  1  last output beat.
- ready_out  in  1  downstream ready.
- valid_insert  in  1  header valid.
- data_insert  in  DATA_WD  header bytes, right-aligned (valid bytes in LSBs).
- keep_insert  in  DATA_BYTE_WD  header byte enables; must equal (1<<byte_insert_cnt)-1.
- byte_insert_cnt  in  BYTE_CNT_WD  header length H, legal range 0..DATA_BYTE_WD.
- ready_insert  out  1  header ready.

Behaviour:
- The clock is clk; the reset rst_n is asynchronous and active-low.
- States:
  - WAIT_HDR (reset state).
  - STREAM.
  - EXTRA.
- Registers:
  - res_data (reset 0), res_keep (reset 0): residual data and byte enables.
  - h_r (reset 0): latched header length H.
  - state.
- Reset values: valid_out=0, ready_in=0, last_out=0, keep_out=0, ready_insert=1. data_out is don't-care whenever valid_out=0.
- WAIT_HDR:
  - ready_insert=1, ready_in=0, valid_out=0.
  - On valid_insert: load res_data<=data_insert, res_keep<=keep_insert, h_r<=byte_insert_cnt, then go to STREAM.
- STREAM:
  - valid_out=valid_in, ready_in=ready_out, ready_insert=0.
  - data_out = ({res_data,data_in} >> 8*h_r)[DATA_WD-1:0].
  - keep_out = ({res_keep,keep_in} >> h_r)[DATA_BYTE_WD-1:0].
  - Payload fire: res_data<=data_in, res_keep<=keep_in.
- Extra-beat rule:
  - need_extra = |(keep_in << (DATA_BYTE_WD-h_r)), evaluated as DATA_BYTE_WD-bit truncation.
  - It is set when the last beat holds more than DATA_BYTE_WD-H bytes.
  - last_out = last_in && !need_extra.
  - Fire with last_in: if need_extra, go to EXTRA; else go to WAIT_HDR.
- EXTRA:
  - valid_out=1, last_out=1, ready_in=0, ready_insert=0.
  - data and keep use the same shift with the lower word forced to 0.
  - On ready_out: go to WAIT_HDR.
- H=0: pure pass-through; need_extra is always 0.
- H=DATA_BYTE_WD: the whole-beat header goes out first, and payload is delayed by exactly one beat; EXTRA always occurs.
- Backpressure: while valid_out && !ready_out, data_out, keep_out and last_out stay stable, and the registers hold.
- The next header is not accepted before the current packet's final output beat fires. There is no overlap, so at least one bubble appears between packets.
- Latency: header to first output is 1 cycle (register load). Payload to output is combinational.
- Reset mid-packet: the packet is dropped, the block returns to WAIT_HDR, and no partial last_out is emitted.
- Illegal inputs (H>DATA_BYTE_WD, keep_insert inconsistent with byte_insert_cnt, non-contiguous keep_in): covered by bench assertions only; RTL behaviour is undefined.

Decomposition:
- Shared package stream_pkg:
  - state encoding localparams (WAIT_HDR, STREAM, EXTRA);
  - default DATA_WD;
  - a byte-count-to-keep-mask function.
- One combinational sub-module, stream_byte_shift: right-shifts a double-width {hi,lo} word and keep pair by a byte count. It is reused by the remove block.

Test Plan:
1. DATA_WD=32, H=2, data_insert=32'h0000AABB, keep_insert=0011; payload 32'h11223344 keep 1111 last → out AABB1122 keep 1111 last=0, then 3344xxxx keep 1100 last=1.
2. H=2; payload 11223344/1111, then 5566xxxx/1100 last → out AABB1122/1111, then 33445566/1111 last=1; no EXTRA.
3. H=0; 3-beat packet, last keep 1110 → output identical to input, same cycle, ready_insert high only between packets.
4. H=4, header DEADBEEF; payload 11223344/1111, 5566xxxx/1100 last → out DEADBEEF, 11223344, 5566xxxx/1100 last.
5. Random ready_out and valid_in toggling over 200 packets with random H (0..4) and random lengths → scoreboard matches header++payload bytes; outputs stable while stalled.
6. Assert rst_n in STREAM mid-packet → valid_out=0 asynchronously, ready_insert=1 after release, next packet correct.
